mem_stage_ctrl: RTL and testbench

//  Sequences the data-memory access for the MEM stage of the MIPS pipeline.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/mem_stage_ctrl_if.sv | 28 ++
 rtl/mem_stage_ctrl_wait_counter.sv | 42 ++++
 rtl/mem_stage_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS MEM-stage memory controller.
//   DATA_W        - datapath width
//   ADDR_BASE_DEF - default byte address that maps to SRAM word 0
//   mem_state_t   - MEM-stage access FSM states
//   cnt_width()   - width for a counter that holds 0..n-1, never below 1 bit
package mips_pkg;

   localparam int DATA_W        = 32;
   localparam int ADDR_BASE_DEF = 1024;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mem_state_t;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Pipeline-side bundle between the EXE/MEM register and the MEM-stage controller.
//   MEM_R_en, MEM_W_en - load / store request from EXE/MEM
//   ALU_result         - byte address
//   ST_value           - store data
//   MEM_result         - last read data, towards MEM/WB
//   ready              - 1 = pipeline may advance, 0 = freeze
// Modports: master = pipeline registers, slave = memory controller.
interface mem_stage_ctrl_if;
   import mips_pkg::*;

   logic              MEM_R_en;
   logic              MEM_W_en;
   logic [DATA_W-1:0] ALU_result;
   logic [DATA_W-1:0] ST_value;
   logic [DATA_W-1:0] MEM_result;
   logic              ready;

   modport master (
      output MEM_R_en, MEM_W_en, ALU_result, ST_value,
      input  MEM_result, ready
   );

   modport slave (
      input  MEM_R_en, MEM_W_en, ALU_result, ST_value,
      output MEM_result, ready
   );

endinterface

// File: rtl/mem_stage_ctrl_wait_counter.sv
// Loadable down-counter that times the SRAM wait states.
//   clk, rst  - clock, synchronous active-high reset (count -> 0)
//   load      - load load_val (has priority over dec)
//   load_val  - value to load
//   dec       - decrement by one; holds at zero
//   cnt       - current count
//   zero      - cnt == 0
module mem_wait_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory sequencer: runs the EXE/MEM request against a
// fixed-latency SRAM with WAIT_CYCLES wait states and freezes the pipeline
// (ready=0) until the access completes.
//   clk, rst     - pipeline clock, synchronous active-high reset
//   pipe         - mem_stage_ctrl_if.slave (request in, MEM_result/ready out)
//   sram_rdata   - SRAM read data
//   sram_addr    - SRAM word address
//   sram_wdata   - SRAM write data
//   sram_ce_n/oe_n/we_n - active-low SRAM strobes, all registered
//   stall_count  - cycles with ready==0, saturating; only with MEM_CTRL_PERF_EN
// Optional feature macro: MEM_CTRL_PERF_EN.
//
// state  | meaning
// IDLE   | no access; a request latches addr/data/kind and starts the access
// ACCESS | SRAM strobes active, wait counter running down
// DONE   | access finished, ready=1 for one cycle, request ignored
module mem_stage_ctrl
   import mips_pkg::*;
#(
   parameter int WAIT_CYCLES = 4,
   parameter int ADDR_BASE   = ADDR_BASE_DEF,
   parameter int SRAM_ADDR_W = 17
) (
   input  logic                   clk,
   input  logic                   rst,
   mem_stage_ctrl_if.slave        pipe,
   input  logic [DATA_W-1:0]      sram_rdata,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0]      sram_wdata,
   output logic                   sram_ce_n,
   output logic                   sram_oe_n,
   output logic                   sram_we_n
`ifdef MEM_CTRL_PERF_EN
   ,
   output logic [31:0]            stall_count
`endif
);

   localparam int CNT_W = cnt_width(WAIT_CYCLES);

   mem_state_t state_q, state_d;

   logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   logic [DATA_W-1:0]      result_q, result_d;
   logic                   is_wr_q, is_wr_d;
   logic                   ce_n_q, ce_n_d;
   logic                   oe_n_q, oe_n_d;
   logic                   we_n_q, we_n_d;

   logic                   req;
   logic [DATA_W-1:0]      byte_off;
   logic [SRAM_ADDR_W-1:0] req_addr;
   logic                   cnt_load;
   logic                   cnt_dec;
   logic                   cnt_zero;
   logic [CNT_W-1:0]       cnt_val;
   logic                   ready_c;

   assign req = pipe.MEM_R_en | pipe.MEM_W_en;

   // Out-of-window addresses simply wrap; the subtraction and truncation are modular.
   assign byte_off = pipe.ALU_result - DATA_W'(ADDR_BASE);
   assign req_addr = SRAM_ADDR_W'(byte_off >> 2);

   mem_wait_counter #(
      .CNT_W (CNT_W)
   ) u_wait_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (CNT_W'(WAIT_CYCLES - 1)),
      .dec      (cnt_dec),
      .cnt      (cnt_val),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      is_wr_d  = is_wr_q;
      result_d = result_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               state_d  = ACCESS;
               cnt_load = 1'b1;
               addr_d   = req_addr;
               wdata_d  = pipe.ST_value;
               // Read+write together is illegal; the write wins.
               is_wr_d  = pipe.MEM_W_en;
            end
         end
         ACCESS: begin
            if (cnt_zero) begin
               state_d = DONE;
               if (!is_wr_q) begin
                  result_d = sram_rdata;
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         DONE: begin
            // The frozen request is still on the inputs here; never re-issue it.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Strobes are registered from the next state so the SRAM only sees flop outputs.
   always_comb begin
      ce_n_d = ~(state_d == ACCESS);
      oe_n_d = ~((state_d == ACCESS) && !is_wr_d);
      we_n_d = ~((state_d == ACCESS) &&  is_wr_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         is_wr_q  <= 1'b0;
         result_q <= '0;
         ce_n_q   <= 1'b1;
         oe_n_q   <= 1'b1;
         we_n_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         is_wr_q  <= is_wr_d;
         result_q <= result_d;
         ce_n_q   <= ce_n_d;
         oe_n_q   <= oe_n_d;
         we_n_q   <= we_n_d;
      end
   end

   assign ready_c = (state_q == DONE) | ((state_q == IDLE) & ~req) | rst;

   assign pipe.ready      = ready_c;
   assign pipe.MEM_result = result_q;
   assign sram_addr       = addr_q;
   assign sram_wdata      = wdata_q;
   assign sram_ce_n       = ce_n_q;
   assign sram_oe_n       = oe_n_q;
   assign sram_we_n       = we_n_q;

`ifdef MEM_CTRL_PERF_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (!ready_c && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;
   import mips_pkg::*;

   logic clk;
   logic rst;

   mem_stage_ctrl_if pipe_a ();
   mem_stage_ctrl_if pipe_b ();

   logic [31:0] rdata_a, rdata_b;
   logic [16:0] addr_a, addr_b;
   logic [31:0] wdata_a, wdata_b;
   logic        ce_a, oe_a, we_a, ce_b, oe_b, we_b;
`ifdef MEM_CTRL_PERF_EN
   logic [31:0] stall_a, stall_b;
`endif

   mem_stage_ctrl #(.WAIT_CYCLES(4), .ADDR_BASE(1024), .SRAM_ADDR_W(17)) dut_a (
      .clk        (clk),
      .rst        (rst),
      .pipe       (pipe_a),
      .sram_rdata (rdata_a),
      .sram_addr  (addr_a),
      .sram_wdata (wdata_a),
      .sram_ce_n  (ce_a),
      .sram_oe_n  (oe_a),
      .sram_we_n  (we_a)
`ifdef MEM_CTRL_PERF_EN
      ,
      .stall_count(stall_a)
`endif
   );

   mem_stage_ctrl #(.WAIT_CYCLES(1), .ADDR_BASE(1024), .SRAM_ADDR_W(17)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .pipe       (pipe_b),
      .sram_rdata (rdata_b),
      .sram_addr  (addr_b),
      .sram_wdata (wdata_b),
      .sram_ce_n  (ce_b),
      .sram_oe_n  (oe_b),
      .sram_we_n  (we_b)
`ifdef MEM_CTRL_PERF_EN
      ,
      .stall_count(stall_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rs;
      logic        r_en;
      logic        w_en;
      logic [31:0] alu;
      logic [31:0] st;
      logic [31:0] rd;
      logic        rdy;
      logic        ce_n;
      logic        oe_n;
      logic        we_n;
      logic [16:0] addr;
      logic [31:0] wd;
      logic [31:0] res;
   } vec_t;

   localparam int NV = 36;
   vec_t vecs [NV];

   int checks   = 0;
   int failures = 0;

   function automatic vec_t mk(input logic rs, input logic r, input logic w,
                               input logic [31:0] alu, input logic [31:0] st,
                               input logic [31:0] rd, input logic rdy,
                               input logic ce, input logic oe, input logic we,
                               input logic [16:0] ad, input logic [31:0] wd,
                               input logic [31:0] res);
      vec_t v;
      v.rs = rs; v.r_en = r; v.w_en = w; v.alu = alu; v.st = st; v.rd = rd;
      v.rdy = rdy; v.ce_n = ce; v.oe_n = oe; v.we_n = we;
      v.addr = ad; v.wd = wd; v.res = res;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive_b(input logic r, input logic [31:0] alu, input logic [31:0] rd);
      pipe_b.MEM_R_en   = r;
      pipe_b.MEM_W_en   = 1'b0;
      pipe_b.ALU_result = alu;
      pipe_b.ST_value   = 32'h0;
      rdata_b           = rd;
   endtask

   localparam logic [31:0] DB = 32'hDEADBEEF;
   localparam logic [31:0] CF = 32'hCAFEF00D;
   localparam logic [31:0] W1 = 32'h12345678;
   localparam logic [31:0] BF = 32'h0BADF00D;
   localparam logic [31:0] A5 = 32'hA5A5A5A5;
   localparam logic [31:0] R1 = 32'h11111111;
   localparam logic [31:0] R2 = 32'h22222222;
   localparam logic [31:0] R3 = 32'h33333333;

   initial begin
      int stall_model;
      string tag;

      // reset + single read (test 1), request held through DONE then dropped (test 3)
      vecs[0] = mk(0,0,0,   0, 0,DB, 1,1,1,1,0, 0, 0);
      vecs[1] = mk(0,1,0,1028, 0,DB, 0,1,1,1,0, 0, 0);
      for (int i = 2; i <= 5; i++) vecs[i] = mk(0,1,0,1028,0,DB, 0,0,0,1,1,0,0);
      vecs[6] = mk(0,1,0,1028, 0,DB, 1,1,1,1,1, 0,DB);
      vecs[7] = mk(0,0,0,1028, 0,DB, 1,1,1,1,1, 0,DB);
      // write (test 2), held through DONE, new read right after DONE (test 3)
      vecs[8] = mk(0,0,1,1032,W1,CF, 0,1,1,1,1, 0,DB);
      for (int i = 9; i <= 12; i++) vecs[i] = mk(0,0,1,1032,W1,CF, 0,0,1,0,2,W1,DB);
      vecs[13] = mk(0,0,1,1032,W1,CF, 1,1,1,1,2,W1,DB);
      vecs[14] = mk(0,1,0,1036, 0,BF, 0,1,1,1,2,W1,DB);
      for (int i = 15; i <= 18; i++) vecs[i] = mk(0,1,0,1036,0,BF, 0,0,0,1,3,0,DB);
      vecs[19] = mk(0,1,0,1036, 0,BF, 1,1,1,1,3, 0,BF);
      // read+write together at ADDR_BASE (test 4)
      vecs[20] = mk(0,1,1,1024,A5,R1, 0,1,1,1,3, 0,BF);
      for (int i = 21; i <= 24; i++) vecs[i] = mk(0,1,1,1024,A5,R1, 0,0,1,0,0,A5,BF);
      vecs[25] = mk(0,0,0,1024,A5,R1, 1,1,1,1,0,A5,BF);
      // reset in the middle of a read, fresh read right after (test 5)
      vecs[26] = mk(0,1,0,1040, 0,R2, 0,1,1,1,0,A5,BF);
      vecs[27] = mk(0,1,0,1040, 0,R2, 0,0,0,1,4, 0,BF);
      vecs[28] = mk(1,1,0,1040, 0,R2, 1,0,0,1,4, 0,BF);
      vecs[29] = mk(0,1,0,1044, 0,R3, 0,1,1,1,0, 0, 0);
      for (int i = 30; i <= 33; i++) vecs[i] = mk(0,1,0,1044,0,R3, 0,0,0,1,5,0,0);
      vecs[34] = mk(0,0,0,1044, 0,R3, 1,1,1,1,5, 0,R3);
      vecs[35] = mk(0,0,0,   0, 0, 0, 1,1,1,1,5, 0,R3);

      rst = 1'b1;
      pipe_a.MEM_R_en = 1'b0; pipe_a.MEM_W_en = 1'b0;
      pipe_a.ALU_result = '0; pipe_a.ST_value = '0; rdata_a = '0;
      drive_b(1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;

      stall_model = 0;
      for (int i = 0; i < NV; i++) begin
         rst               = vecs[i].rs;
         pipe_a.MEM_R_en   = vecs[i].r_en;
         pipe_a.MEM_W_en   = vecs[i].w_en;
         pipe_a.ALU_result = vecs[i].alu;
         pipe_a.ST_value   = vecs[i].st;
         rdata_a           = vecs[i].rd;
         @(negedge clk);
         tag = $sformatf("v%0d", i);
         chk({tag, "_ready"},  {31'b0, pipe_a.ready}, {31'b0, vecs[i].rdy});
         chk({tag, "_ce_n"},   {31'b0, ce_a},         {31'b0, vecs[i].ce_n});
         chk({tag, "_oe_n"},   {31'b0, oe_a},         {31'b0, vecs[i].oe_n});
         chk({tag, "_we_n"},   {31'b0, we_a},         {31'b0, vecs[i].we_n});
         chk({tag, "_addr"},   {15'b0, addr_a},       {15'b0, vecs[i].addr});
         chk({tag, "_wdata"},  wdata_a,               vecs[i].wd);
         chk({tag, "_result"}, pipe_a.MEM_result,     vecs[i].res);
         if (vecs[i].rs) stall_model = 0;
         else if (!vecs[i].rdy) stall_model++;
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
`ifdef MEM_CTRL_PERF_EN
      @(negedge clk);
      chk("a_stall_count", stall_a, 32'(stall_model));
      @(posedge clk);
      #1;
`endif

      // WAIT_CYCLES=1, back-to-back reads, first address below ADDR_BASE, second beyond the SRAM
      drive_b(1'b1, 32'd1020, 32'h0);
      @(negedge clk);
      chk("b_c0_ready", {31'b0, pipe_b.ready}, 32'd0);
      @(posedge clk); #1;
      drive_b(1'b1, 32'd1020, 32'h5A5A0001);
      @(negedge clk);
      chk("b_c1_ready", {31'b0, pipe_b.ready}, 32'd0);
      chk("b_c1_oe_n",  {31'b0, oe_b},         32'd0);
      chk("b_c1_addr_wrap_low", {15'b0, addr_b}, 32'h0001FFFF);
      @(posedge clk); #1;
      drive_b(1'b1, 32'd1020, 32'h0);
      @(negedge clk);
      chk("b_c2_ready",  {31'b0, pipe_b.ready}, 32'd1);
      chk("b_c2_ce_n",   {31'b0, ce_b},         32'd1);
      chk("b_c2_result", pipe_b.MEM_result,     32'h5A5A0001);
      @(posedge clk); #1;
      drive_b(1'b1, 32'd525320, 32'h0);
      @(negedge clk);
      chk("b_c3_ready", {31'b0, pipe_b.ready}, 32'd0);
      @(posedge clk); #1;
      drive_b(1'b1, 32'd525320, 32'h5A5A0002);
      @(negedge clk);
      chk("b_c4_ready", {31'b0, pipe_b.ready}, 32'd0);
      chk("b_c4_addr_wrap_high", {15'b0, addr_b}, 32'd2);
      @(posedge clk); #1;
      drive_b(1'b1, 32'd525320, 32'h0);
      @(negedge clk);
      chk("b_c5_ready",  {31'b0, pipe_b.ready}, 32'd1);
      chk("b_c5_result", pipe_b.MEM_result,     32'h5A5A0002);
      @(posedge clk); #1;
      drive_b(1'b0, 32'd0, 32'h0);
      @(negedge clk);
      chk("b_c6_ready", {31'b0, pipe_b.ready}, 32'd1);
      chk("b_c6_ce_n",  {31'b0, ce_b},         32'd1);
`ifdef MEM_CTRL_PERF_EN
      chk("b_stall_count", stall_b, 32'd4);
`endif
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
